// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the fetch front end.
package rv_pipe_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory, redirect and IF/ID handshake signals of the prefetch unit.
interface if_prefetch_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_inst;
   logic            out_ready;

   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Shift-register queue of fetch entries; entry 0 is always the head, so the head is a flop.
module fetch_fifo
   import rv_pipe_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic         full,
   output logic         empty,
   output logic [CW-1:0] occ,
   output fetch_entry_t head
);
   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t  entries_q [DEPTH];
   fetch_entry_t  entries_d [DEPTH];
   logic [CW-1:0] occ_q, occ_d, wr_pos;
   logic          push_ok, pop_ok;

   assign full    = (occ_q == CW'(DEPTH));
   assign empty   = (occ_q == '0);
   assign occ     = occ_q;
   assign head    = entries_q[0];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (pop_ok || !full);

   always_comb begin
      entries_d = entries_q;
      // With a pop the tail slides down one place, so the new word lands one slot lower.
      wr_pos = pop_ok ? occ_q - CW'(1) : occ_q;
      if (pop_ok) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            entries_d[i] = entries_q[i+1];
         end
      end
      if (push_ok) begin
         entries_d[wr_pos[AW-1:0]] = din;
      end
      occ_d = occ_q + CW'(push_ok) - CW'(pop_ok);
      if (flush) begin
         occ_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         occ_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         occ_q     <= occ_d;
         entries_q <= entries_d;
      end
   end

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch front end: owns the fetch PC, issues credited word reads and buffers responses for IF/ID.
module if_prefetch_unit #(
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     XLEN     = rv_pipe_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = rv_pipe_pkg::RESET_PC
) (
   input logic                 clk,
   input logic                 rst,
   if_prefetch_unit_if.master  bus
);
   import rv_pipe_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] MAX_CREDITS = DEPTH[CW:0];

   logic [XLEN-1:0] fpc_q, rpc_q, redirect_tgt;
   logic [CW-1:0]   inflight_q, discard_q, occ;
   logic [CW:0]     credits_used;
   logic            run_q, full, empty, push, pop, req_fire;
   logic            unused_pc_lsbs;
   fetch_entry_t    rsp_entry, head;

   assign redirect_tgt   = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

   // Credits cover both outstanding requests and buffered words, so a push never meets a full queue.
   assign credits_used       = {1'b0, inflight_q} + {1'b0, occ};
   assign bus.imem_req_valid = run_q && !bus.redirect_valid && !full
                               && (credits_used < MAX_CREDITS);
   assign bus.imem_req_addr  = fpc_q;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   assign push      = bus.imem_rsp_valid && (discard_q == '0) && !bus.redirect_valid;
   assign rsp_entry = '{pc: rpc_q, inst: bus.imem_rsp_data};

   assign bus.out_valid = !empty && !bus.redirect_valid;
   assign bus.out_pc    = head.pc;
   assign bus.out_inst  = head.inst;
   assign pop           = bus.out_valid && bus.out_ready;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_valid),
      .din   (rsp_entry),
      .full  (full),
      .empty (empty),
      .occ   (occ),
      .head  (head)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         fpc_q      <= RESET_PC;
         rpc_q      <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         run_q      <= 1'b0;
      end else begin
         run_q      <= 1'b1;
         inflight_q <= inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
         if (bus.redirect_valid) begin
            fpc_q     <= redirect_tgt;
            rpc_q     <= redirect_tgt;
            // Every response still owed after this edge belongs to the abandoned stream.
            discard_q <= inflight_q - CW'(bus.imem_rsp_valid);
         end else begin
            if (req_fire) begin
               fpc_q <= fpc_q + XLEN'(4);
            end
            if (push) begin
               rpc_q <= rpc_q + XLEN'(4);
            end
            if (bus.imem_rsp_valid && (discard_q != '0)) begin
               discard_q <= discard_q - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with an in-order, fixed-latency instruction memory model.
module tb_if_prefetch_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_prefetch_unit_if #(.XLEN(32)) bus ();

   if_prefetch_unit #(
      .DEPTH    (4),
      .XLEN     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend[$];
   int    tests = 0;
   int    fails = 0;
   int    cyc   = 0;
   int    lat   = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory acts mid-cycle, once the bench has settled this cycle's inputs.
   always @(negedge clk) begin
      if (!rst) begin
         pend.delete();
         bus.imem_rsp_valid = 1'b0;
      end else begin
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
         end
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Holds reset for two edges and returns at the start of the first running cycle.
   task automatic restart();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      int exp_occ [10] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};
      int exp_rv  [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

      rst                = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b1;

      // Reset state
      tick();
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_pc", bus.out_pc, 32'h0);
      check("rst_out_inst", bus.out_inst, 32'h0);
      check("rst_occ", 32'(dut.occ), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // Streaming with a single-cycle memory
      for (int k = 0; k < 6; k++) begin
         check("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
         check("t1_req_addr", bus.imem_req_addr, 32'(4 * k));
         if (k >= 2) begin
            check("t1_out_valid", 32'(bus.out_valid), 32'd1);
            check("t1_out_pc", bus.out_pc, 32'(4 * (k - 2)));
            check("t1_out_inst", bus.out_inst, 32'hC0DE_0000 ^ 32'(4 * (k - 2)));
         end
         tick();
      end

      // Decode stall fills the queue and stops issue
      bus.out_ready = 1'b0;
      restart();
      for (int k = 0; k < 10; k++) begin
         check("t2_occ", 32'(dut.occ), 32'(exp_occ[k]));
         check("t2_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv[k]));
         tick();
      end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("t2_drain_valid", 32'(bus.out_valid), 32'd1);
         check("t2_drain_pc", bus.out_pc, 32'(4 * k));
         tick();
      end

      // Redirect with three requests outstanding at latency 3
      lat = 3;
      restart();
      tick();
      tick();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0100;
      #1;
      check("t3_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      check("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("t3_req_addr", bus.imem_req_addr, 32'h0000_0100);
      for (int k = 0; k < 4; k++) begin
         check("t3_stale_hidden", 32'(bus.out_valid), 32'd0);
         tick();
      end
      check("t3_out_valid", 32'(bus.out_valid), 32'd1);
      check("t3_out_pc", bus.out_pc, 32'h0000_0100);
      check("t3_out_inst", bus.out_inst, 32'hC0DE_0100);
      check("t3_discard", 32'(dut.discard_q), 32'd0);

      // Redirect coinciding with a response, then a second redirect
      lat = 2;
      restart();
      tick();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0100;
      #1;
      check("t4_redir1_req_valid", 32'(bus.imem_req_valid), 32'd0);
      tick();
      bus.redirect_pc = 32'h0000_0200;
      #1;
      check("t4_redir2_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("t4_redir2_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      check("t4_req_addr", bus.imem_req_addr, 32'h0000_0200);
      check("t4_discard_early", 32'(dut.discard_q), 32'd0);
      tick();
      check("t4_req_addr2", bus.imem_req_addr, 32'h0000_0204);
      check("t4_gap_valid_a", 32'(bus.out_valid), 32'd0);
      tick();
      check("t4_gap_valid_b", 32'(bus.out_valid), 32'd0);
      tick();
      check("t4_out_valid", 32'(bus.out_valid), 32'd1);
      check("t4_out_pc", bus.out_pc, 32'h0000_0200);
      check("t4_out_inst", bus.out_inst, 32'hC0DE_0200);
      tick();
      check("t4_out_pc2", bus.out_pc, 32'h0000_0204);
      check("t4_out_inst2", bus.out_inst, 32'hC0DE_0204);
      check("t4_discard", 32'(dut.discard_q), 32'd0);

      // Misaligned redirect target is word-aligned
      lat = 1;
      restart();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      #1;
      check("t5_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("t5_redir_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      check("t5_req_addr", bus.imem_req_addr, 32'h0000_0100);
      tick();
      check("t5_gap_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("t5_out_valid", 32'(bus.out_valid), 32'd1);
      check("t5_out_pc", bus.out_pc, 32'h0000_0100);

      // Reset with two requests in flight and two words queued
      lat           = 3;
      bus.out_ready = 1'b0;
      restart();
      for (int k = 0; k < 5; k++) tick();
      check("t6_pre_occ", 32'(dut.occ), 32'd2);
      check("t6_pre_inflight", 32'(dut.inflight_q), 32'd2);
      rst = 1'b0;
      tick();
      check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("t6_rst_occ", 32'(dut.occ), 32'd0);
      rst           = 1'b1;
      lat           = 1;
      bus.out_ready = 1'b1;
      tick();
      check("t6_req_addr", bus.imem_req_addr, 32'h0000_0000);
      check("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
      tick();
      check("t6_gap_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("t6_out_pc0", bus.out_pc, 32'h0000_0000);
      check("t6_out_inst0", bus.out_inst, 32'hC0DE_0000);
      tick();
      check("t6_out_pc1", bus.out_pc, 32'h0000_0004);
      check("t6_out_valid1", 32'(bus.out_valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "timeout");
   end

endmodule
